ghash_reduce: RTL and testbench

Pipelined reducer for GF(2^128) products, modulo x^128 + x^7 + x^2 + x + 1. It sits directly downstream of the `karatsuba` multiplier, which supplies a 256-bit carry-less product per transfer. The block folds that product into a 128-bit field element for the GHASH accumulator. Its valid/enable contract matches `karatsuba`, so the two chain with no glue logic.

---
 rtl/ghash_reduce.sv | 137 +++++++++++++
 tb/tb_ghash_reduce.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ghash_reduce.sv
// -----------------------------------------------------------------------------
// ghash_reduce
//
// Reduces a 256-bit carry-less product modulo x^128 + x^7 + x^2 + x + 1 into
// a 128-bit GF(2^128) element for the GHASH accumulator. It chains directly
// behind the karatsuba multiplier and shares its valid/enable handshake.
//
// Reduction is done as two XOR-only folds using x^128 == x^7 + x^2 + x + 1:
//   fold 1: T      = L ^ H ^ H<<1 ^ H<<2 ^ H<<7     (135 bits, H/L = halves)
//   fold 2: result = T[127:0] ^ E ^ E<<1 ^ E<<2 ^ E<<7,  E = T[134:128]
// Fold 2 cannot overflow: E has degree <= 6, so E<<7 has degree <= 13.
//
// Build option (macro GHASH_REDUCE_2STAGE_EN):
//   defined     : fold 1 registered, then fold 2 registered (latency 2)
//   not defined : both folds feed a single output register (latency 1)
// Results are bit-identical in both builds.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   synchronous active-low reset; clears valid and data regs,
//                  overrides en
//   en        in   pipeline advance; when low every register holds and the
//                  input is ignored
//   valid_i   in   prod_i carries a product this cycle
//   prod_i    in   [2*WIDTH-1:0] carry-less product, bit k = coeff of x^k
//   valid_o   out  result_o carries a reduced element (registered)
//   result_o  out  [WIDTH-1:0] reduced element, bit k = coeff of x^k
//
// Parameter WIDTH is fixed at 128 because the reduction polynomial is fixed.
// -----------------------------------------------------------------------------
module ghash_reduce #(
    parameter int WIDTH = 128
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               valid_i,
    input  logic [2*WIDTH-1:0] prod_i,
    output logic               valid_o,
    output logic [WIDTH-1:0]   result_o
);

    // Fold-1 result width: H<<7 reaches bit WIDTH+6.
    localparam int TW = WIDTH + 7;

    // First fold: replace H*x^128 by H*(x^7 + x^2 + x + 1).
    function automatic logic [TW-1:0] fold1(input logic [2*WIDTH-1:0] p);
        logic [TW-1:0] h_w;
        logic [TW-1:0] l_w;
        h_w = TW'(p[2*WIDTH-1:WIDTH]);
        l_w = TW'(p[WIDTH-1:0]);
        return l_w ^ h_w ^ (h_w << 1) ^ (h_w << 2) ^ (h_w << 7);
    endfunction

    // Second fold of the 7-bit overflow E; result fits in WIDTH bits.
    function automatic logic [WIDTH-1:0] fold2(input logic [TW-1:0] t);
        logic [WIDTH-1:0] e_w;
        e_w = WIDTH'(t[TW-1:WIDTH]);
        return t[WIDTH-1:0] ^ e_w ^ (e_w << 1) ^ (e_w << 2) ^ (e_w << 7);
    endfunction

`ifdef GHASH_REDUCE_2STAGE_EN

    logic             vld_p1_q, vld_p1_d;
    logic [TW-1:0]    t_p1_q,   t_p1_d;
    logic             vld_p2_q, vld_p2_d;
    logic [WIDTH-1:0] res_p2_q, res_p2_d;

    always_comb begin
        vld_p1_d = vld_p1_q;
        t_p1_d   = t_p1_q;
        vld_p2_d = vld_p2_q;
        res_p2_d = res_p2_q;
        if (en) begin
            // Stage 1 boundary: product -> T
            vld_p1_d = valid_i;
            if (valid_i) begin
                t_p1_d = fold1(prod_i);
            end
            // Stage 2 boundary: T -> reduced element
            vld_p2_d = vld_p1_q;
            if (vld_p1_q) begin
                res_p2_d = fold2(t_p1_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1_q <= 1'b0;
            t_p1_q   <= '0;
            vld_p2_q <= 1'b0;
            res_p2_q <= '0;
        end else begin
            vld_p1_q <= vld_p1_d;
            t_p1_q   <= t_p1_d;
            vld_p2_q <= vld_p2_d;
            res_p2_q <= res_p2_d;
        end
    end

    assign valid_o  = vld_p2_q;
    assign result_o = res_p2_q;

`else

    logic             vld_p1_q, vld_p1_d;
    logic [WIDTH-1:0] res_p1_q, res_p1_d;

    always_comb begin
        vld_p1_d = vld_p1_q;
        res_p1_d = res_p1_q;
        if (en) begin
            // Stage 1 boundary: product -> reduced element (both folds)
            vld_p1_d = valid_i;
            if (valid_i) begin
                res_p1_d = fold2(fold1(prod_i));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1_q <= 1'b0;
            res_p1_q <= '0;
        end else begin
            vld_p1_q <= vld_p1_d;
            res_p1_q <= res_p1_d;
        end
    end

    assign valid_o  = vld_p1_q;
    assign result_o = res_p1_q;

`endif

endmodule

// File: tb/tb_ghash_reduce.sv
module tb_ghash_reduce;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic         valid_i;
    logic [255:0] prod_i;
    logic         valid_o;
    logic [127:0] result_o;

    ghash_reduce #(.WIDTH(128)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .valid_i  (valid_i),
        .prod_i   (prod_i),
        .valid_o  (valid_o),
        .result_o (result_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int pops   = 0;
    int cyc    = 0;
    bit mute   = 1'b0;

    logic [127:0] sb[$];
    int           pop_cyc[$];

    always @(posedge clk) cyc++;

    // Reference: bitwise long division by x^128 + x^7 + x^2 + x + 1.
    function automatic logic [127:0] ref_reduce(input logic [255:0] p);
        logic [255:0] r;
        logic [255:0] poly;
        r = p;
        poly = '0;
        poly[128] = 1'b1;
        poly[7:0] = 8'h87;
        for (int i = 255; i >= 128; i--) begin
            if (r[i]) r = r ^ (poly << (i - 128));
        end
        return r[127:0];
    endfunction

    // Monitor / scoreboard: count a result when valid_o && en; while stalled
    // the held result must match the head of the queue.
    always @(negedge clk) begin
        if (!mute && rst_n && valid_o) begin
            if (en) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid: result_o=%h, required no output", result_o);
                end else begin
                    logic [127:0] exp_v;
                    exp_v = sb.pop_front();
                    pops++;
                    pop_cyc.push_back(cyc);
                    if (result_o !== exp_v) begin
                        errors++;
                        $display("FAIL result: got %h, required %h", result_o, exp_v);
                    end
                end
            end else if (sb.size() != 0) begin
                checks++;
                if (result_o !== sb[0]) begin
                    errors++;
                    $display("FAIL stall_hold: got %h, required %h", result_o, sb[0]);
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [255:0] p, input logic e,
                         input logic [127:0] exp_v, input bit push);
        @(posedge clk); #1;
        valid_i = v;
        prod_i  = p;
        en      = e;
        if (push && v && e && rst_n) sb.push_back(exp_v);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b1, '0, 1'b0);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
        idle(4);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d results outstanding, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp_v);
        end
    endtask

    task automatic check_vec(input string name, input logic [127:0] act, input logic [127:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp_v);
        end
    endtask

    logic [255:0] stream_vec [10];
    logic [255:0] p;
    int           p0;

    initial begin
        stream_vec[0] = 256'h3a7f_19c2_e4d0_5b86_71aa_0c3e_9f24_d815_6b90_e2f7_0431_ac5d_87be_1f62_d9a4_3c07;
        stream_vec[1] = 256'h0000_0000_0000_0001_ffff_ffff_ffff_ffff_1234_5678_9abc_def0_0fed_cba9_8765_4321;
        stream_vec[2] = 256'hffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff;
        stream_vec[3] = 256'h8000_0000_0000_0000_0000_0000_0000_0001_0000_0000_0000_0000_0000_0000_0000_0080;
        stream_vec[4] = 256'h5a5a_a5a5_5a5a_a5a5_5a5a_a5a5_5a5a_a5a5_c3c3_3c3c_c3c3_3c3c_c3c3_3c3c_c3c3_3c3c;
        stream_vec[5] = 256'h66e9_4bd4_ef8a_2c3b_884c_fa59_ca34_2b2e_0388_dace_60b6_a392_f328_c2b9_71b2_fe78;
        stream_vec[6] = 256'h0123_4567_89ab_cdef_fedc_ba98_7654_3210_0f0f_0f0f_f0f0_f0f0_1111_2222_3333_4444;
        stream_vec[7] = 256'hdead_beef_cafe_babe_0bad_f00d_feed_face_1357_9bdf_2468_ace0_aaaa_5555_0000_ffff;
        stream_vec[8] = 256'h7fff_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000;
        stream_vec[9] = 256'h9e37_79b9_7f4a_7c15_f39c_c060_5ced_c834_1082_276b_f3a2_7251_f86c_6a11_d0c1_8e95;

        // Reset with en and valid_i high: reset must win.
        rst_n = 1'b0; en = 1'b1; valid_i = 1'b1; prod_i = stream_vec[0];
        repeat (3) @(posedge clk);
        #1;
        check_int("reset_valid_o", int'(valid_o), 0);
        check_vec("reset_result_o", result_o, 128'h0);
        rst_n = 1'b1; valid_i = 1'b0; prod_i = '0;
        idle(2);

        // Basic fold: H=1, L=0 -> 0x87, exactly one pulse.
        p0 = pops;
        p = '0; p[128] = 1'b1;
        drive(1'b1, p, 1'b1, 128'h87, 1'b1);
        idle(1);
        drain("basic");
        check_int("basic_pulses", pops - p0, 1);

        // Low-half passthrough and zero.
        p = 256'h0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_dead_beef_0123_4567_89ab_cdef;
        drive(1'b1, p, 1'b1, 128'h0000_0000_dead_beef_0123_4567_89ab_cdef, 1'b1);
        drive(1'b1, '0, 1'b1, 128'h0, 1'b1);
        // Double fold: only bit 255 set.
        p = '0; p[255] = 1'b1;
        drive(1'b1, p, 1'b1, 128'h8000_0000_0000_0000_0000_0000_0000_2049, 1'b1);
        idle(1);
        drain("directed");

        // Streaming: 10 back-to-back products, no gaps at the output.
        pop_cyc.delete();
        p0 = pops;
        for (int i = 0; i < 10; i++) drive(1'b1, stream_vec[i], 1'b1, ref_reduce(stream_vec[i]), 1'b1);
        idle(1);
        drain("stream");
        check_int("stream_pulses", pops - p0, 10);
        if (pop_cyc.size() == 10) begin
            for (int i = 1; i < 10; i++)
                check_int("stream_contiguous", pop_cyc[i] - pop_cyc[i-1], 1);
        end

        // Stall: en low 3 cycles with valid_i high; stalled inputs are ignored.
        p0 = pops;
        for (int i = 0; i < 3; i++) drive(1'b1, stream_vec[i+5], 1'b1, ref_reduce(stream_vec[i+5]), 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b1, stream_vec[i], 1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b1, stream_vec[i+2], 1'b1, ref_reduce(stream_vec[i+2]), 1'b1);
        idle(1);
        drain("stall");
        check_int("stall_pulses", pops - p0, 6);

        // Reset in flight: two products discarded, no output for them.
        p0 = pops;
        mute = 1'b1;
        drive(1'b1, stream_vec[3], 1'b1, '0, 1'b0);
        drive(1'b1, stream_vec[4], 1'b1, '0, 1'b0);
        @(posedge clk); #1;
        valid_i = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_int("inflight_reset_valid_o", int'(valid_o), 0);
        check_vec("inflight_reset_result_o", result_o, 128'h0);
        mute = 1'b0;
        idle(8);
        check_int("inflight_no_output", pops - p0, 0);

        // Pipeline still works after the in-flight reset.
        drive(1'b1, stream_vec[9], 1'b1, ref_reduce(stream_vec[9]), 1'b1);
        idle(1);
        drain("post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
